level_controller: RTL

LEVEL_CONTROLLER -- requirements
Module: level_controller

---
 rtl/level_controller.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/level_controller.sv
// -----------------------------------------------------------------------------
// level_controller
// Game-flow controller for the frog/car game. Tracks the current level, the
// remaining lives and the play state. It also produces the car speed offset
// and a frog-reset pulse whenever the frog must go back to its start square.
//
// Parameters
//   MAX_LEVEL    : highest playable level (1..15)
//   SPEED_STEP   : speed_car increment per level above 1
//   START_LIVES  : lives loaded at game start (1..3)
//   PAUSE_CYCLES : clock cycles spent in the HIT and WIN pauses (>= 2)
//
// Ports
//   CLK        in   single clock, rising edge
//   RST_N      in   synchronous active-low reset
//   start      in   one-cycle start request (debounced button)
//   frog_win   in   one-cycle pulse, frog reached the goal row
//   frog_hit   in   one-cycle pulse, frog collided with a car
//   speed_car  out  [4:0] extra car speed, (level-1)*SPEED_STEP saturated at 31
//   level      out  [3:0] current level, 1..MAX_LEVEL
//   lives      out  [1:0] remaining lives
//   cars_run   out  car movement enable, high only in PLAY
//   frog_reset out  one-cycle pulse returning the frog to its start position
//   game_over  out  high while in GAME_OVER
//   state      out  [2:0] IDLE=0, PLAY=1, HIT=2, WIN=3, GAME_OVER=4
//
// Every output is registered and changes one cycle after the input that
// caused the change.
// -----------------------------------------------------------------------------
module level_controller #(
    parameter int MAX_LEVEL    = 8,
    parameter int SPEED_STEP   = 2,
    parameter int START_LIVES  = 3,
    parameter int PAUSE_CYCLES = 25000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       start,
    input  logic       frog_win,
    input  logic       frog_hit,
    output logic [4:0] speed_car,
    output logic [3:0] level,
    output logic [1:0] lives,
    output logic       cars_run,
    output logic       frog_reset,
    output logic       game_over,
    output logic [2:0] state
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PLAY      = 3'd1;
    localparam logic [2:0] ST_HIT       = 3'd2;
    localparam logic [2:0] ST_WIN       = 3'd3;
    localparam logic [2:0] ST_GAME_OVER = 3'd4;

    localparam logic [3:0]  MAX_LVL    = 4'(MAX_LEVEL);
    localparam logic [1:0]  INIT_LIVES = 2'(START_LIVES);
    // The pause counter is 0-based, so the final pause cycle sees this value.
    localparam logic [24:0] PAUSE_LAST = 25'(PAUSE_CYCLES - 1);

    // Car speed for a given level: product formed at 9 bits, then clamped to
    // the 5-bit output range instead of wrapping.
    function automatic logic [4:0] speed_for_level(input logic [3:0] lvl);
        logic [8:0] prod;
        prod = (9'(lvl) - 9'd1) * 9'(SPEED_STEP);
        if (prod > 9'd31) begin
            return 5'd31;
        end else begin
            return prod[4:0];
        end
    endfunction

    logic [2:0]  r_state;
    logic [3:0]  r_level;
    logic [1:0]  r_lives;
    logic [4:0]  r_speed_car;
    logic        r_cars_run;
    logic        r_frog_reset;
    logic        r_game_over;
    logic [24:0] r_pause_cnt;

    logic [2:0]  w_state_next;
    logic [3:0]  w_level_next;
    logic [1:0]  w_lives_next;
    logic [24:0] w_pause_next;
    logic        w_frog_reset_next;

    // Next-state, level, lives and pause-counter decode.
    always_comb begin
        w_state_next      = r_state;
        w_level_next      = r_level;
        w_lives_next      = r_lives;
        w_pause_next      = 25'd0;
        w_frog_reset_next = 1'b0;

        case (r_state)
            ST_IDLE, ST_GAME_OVER: begin
                if (start) begin
                    w_state_next      = ST_PLAY;
                    w_level_next      = 4'd1;
                    w_lives_next      = INIT_LIVES;
                    w_frog_reset_next = 1'b1;
                end else begin
                    w_state_next = r_state;
                end
            end
            ST_PLAY: begin
                // A hit outranks a simultaneous win; the win is dropped.
                if (frog_hit) begin
                    if (r_lives > 2'd1) begin
                        w_state_next      = ST_HIT;
                        w_lives_next      = r_lives - 2'd1;
                        w_frog_reset_next = 1'b1;
                    end else begin
                        // Last life lost: frog stays where it is.
                        w_state_next = ST_GAME_OVER;
                        w_lives_next = 2'd0;
                    end
                end else if (frog_win) begin
                    w_state_next      = ST_WIN;
                    w_frog_reset_next = 1'b1;
                    if (r_level >= MAX_LVL) begin
                        w_level_next = MAX_LVL;
                    end else begin
                        w_level_next = r_level + 4'd1;
                    end
                end else begin
                    w_state_next = ST_PLAY;
                end
            end
            ST_HIT, ST_WIN: begin
                if (r_pause_cnt == PAUSE_LAST) begin
                    w_state_next = ST_PLAY;
                    w_pause_next = 25'd0;
                end else begin
                    w_pause_next = r_pause_cnt + 25'd1;
                end
            end
            default: begin
                // Unreachable encodings recover to a fresh IDLE.
                w_state_next = ST_IDLE;
                w_level_next = 4'd1;
                w_lives_next = INIT_LIVES;
            end
        endcase
    end

    // State and registered outputs; reset overrides every input.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state      <= ST_IDLE;
            r_level      <= 4'd1;
            r_lives      <= INIT_LIVES;
            r_speed_car  <= 5'd0;
            r_cars_run   <= 1'b0;
            r_frog_reset <= 1'b0;
            r_game_over  <= 1'b0;
            r_pause_cnt  <= 25'd0;
        end else begin
            r_state      <= w_state_next;
            r_level      <= w_level_next;
            r_lives      <= w_lives_next;
            // Derived from the next level so speed moves on the same edge.
            r_speed_car  <= speed_for_level(w_level_next);
            r_cars_run   <= (w_state_next == ST_PLAY);
            r_frog_reset <= w_frog_reset_next;
            r_game_over  <= (w_state_next == ST_GAME_OVER);
            r_pause_cnt  <= w_pause_next;
        end
    end

    assign state      = r_state;
    assign level      = r_level;
    assign lives      = r_lives;
    assign speed_car  = r_speed_car;
    assign cars_run   = r_cars_run;
    assign frog_reset = r_frog_reset;
    assign game_over  = r_game_over;

endmodule
